mesi_snoop_responder: RTL
=========================

Name: mesi_snoop_responder

Overview:
- Snoop-side counterpart to the per-line MESI controller. It watches bus operations issued by other caches, looks up a local direct-mapped tag/state store, and drives the snoop result (HIT/HITM/NOHIT) that requesters sample.
- It applies the snoop-induced MESI transitions and, on HITM, runs a writeback handshake for the dirty line.
- The local controller installs and updates lines through a fill port.

Parameters:
- ADDR_W, 32, address width in bits.
- OFF_W, 6, line-offset bits (64-byte lines).
- IDX_W, 4, set-index bits (16 sets, direct-mapped).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- snoop_valid  in  1  snooped bus operation present.
- snoop_ready  out  1  responder can accept a snoop.
- snoop_op  in  2  bus_op_t: READ=0, WRITE=1, INVALIDATE=2, RWIM=3.
- snoop_addr  in  ADDR_W  snooped byte address.
- result_valid  out  1  one-cycle pulse; snoop_result is valid.
- snoop_result  out  2  snoop_result_t: HIT=00, HITM=01, NOHIT=10.
- wb_valid  out  1  writeback request pending.
- wb_ready  in  1  bus accepts the writeback.
- wb_addr  out  ADDR_W  line-aligned writeback address; offset bits are 0.
- fill_valid  in  1  local state install/update.
- fill_ready  out  1  fill accepted this cycle.
- fill_addr  in  ADDR_W  line address to install.
- fill_state  in  2  states_t: M=01, E=00, S=10, I=11.
- protocol_err  out  1  one-cycle pulse on an illegal snoop/state combination.

Behaviour:
Reset:
- All sets go to state I with tag 0, and FSM goes to IDLE.
- snoop_ready=1, fill_ready=0, result_valid=0, snoop_result=NOHIT, wb_valid=0, wb_addr=0, protocol_err=0.
- Reset mid-operation aborts any lookup or writeback immediately. wb_valid drops on the next edge.

Address split:
- idx = addr[OFF_W+IDX_W-1:OFF_W]; tag = addr[ADDR_W-1:OFF_W+IDX_W].
- hit = (stored tag == tag) && (stored state != I).

FSM states: IDLE, LOOKUP, RESPOND, WRITEBACK.
- IDLE: snoop_ready=1. On snoop_valid, capture op and addr, then go to LOOKUP.
- IDLE fill: fill_ready = !snoop_valid, so a snoop wins a simultaneous fill. An accepted fill writes tag and state into the set that edge and stays in IDLE.
- LOOKUP: one cycle. Registers the set's tag/state and computes the result and next state.
- RESPOND: result_valid=1 for exactly one cycle. The state-table update commits on the edge ending RESPOND.
  - If the result is HITM, go to WRITEBACK with wb_valid=1 asserted in the same cycle as result_valid.
  - Otherwise go to IDLE.
- WRITEBACK: hold wb_valid and wb_addr stable until wb_ready is sampled high, then go to IDLE. wb_ready is ignored outside WRITEBACK.
- snoop_ready and fill_ready are 0 in every state except IDLE.
- Latency: snoop accepted at edge T gives result_valid in cycle T+2. The next snoop can be accepted at T+3 at the earliest (no HITM), i.e. throughput is one snoop per 3 cycles.

Snoop transitions on hit (miss gives NOHIT and no change):
- READ: M->S HITM plus writeback; E->S HIT; S->S HIT.
- RWIM: M->I HITM plus writeback; E->I HIT; S->I HIT.
- INVALIDATE: S->I HIT. On M or E: state unchanged, result NOHIT, protocol_err pulse in the RESPOND cycle.
- WRITE: no state change, result NOHIT. A hit in M, E or S pulses protocol_err.

Output timing:
- snoop_result holds its last value when result_valid=0.
- protocol_err is 0 except for its one-cycle pulse.

Decomposition:
- Package mesi_pkg holds:
  - states_t with the encodings above.
  - bus_op_t.
  - snoop_result_t.
  - The derived widths TAG_W = ADDR_W-OFF_W-IDX_W and SETS = 2**IDX_W.
- Sub-module mesi_snoop_tag_store:
  - 2**IDX_W entries of {tag, state}, synchronously reset to I.
  - One read port, registered in LOOKUP.
  - One write port, muxed between the fill write and the RESPOND commit. These never collide because of the IDLE-only fill rule.

Test Plan:
- Reset, then READ snoop to 0x0000_1040 -> result_valid at T+2 with NOHIT, wb_valid stays 0, snoop_ready back to 1 at T+3.
- Fill 0x0000_1040 as E, then READ snoop to the same line -> HIT; set 1 becomes S; no writeback.
- Fill 0x0000_2080 as M, then RWIM snoop to 0x0000_20A4 -> HITM with wb_valid=1 and wb_addr=0x0000_2080. Hold wb_ready=0 for 3 cycles: wb_valid stays high and snoop_ready stays 0. Raise wb_ready: FSM returns to IDLE and set 2 is I.
- Fill 0x0000_3000 as S, then snoop INVALIDATE to 0x0001_3000 (same set, different tag) -> NOHIT with state unchanged. Then INVALIDATE 0x0000_3000 -> HIT and the set becomes I.
- With the line in M, snoop WRITE to it -> NOHIT, protocol_err pulses for 1 cycle, state remains M.
- Assert fill_valid together with snoop_valid in IDLE -> snoop accepted and fill_ready=0; the fill is accepted on the first IDLE cycle after the response. Also assert rst during WRITEBACK -> wb_valid=0 after the edge and all sets report NOHIT.

Source files
------------

// File: rtl/mesi_pkg.sv
// Purpose : Shared types, default widths and the snoop decision table for the
//           MESI snoop responder.
// Contents: states_t, bus_op_t, snoop_result_t, snoop_decision_t,
//           default widths, derived TAG_W / SETS, snoop_decide().
package mesi_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_OFF_W  = 6;
    localparam int unsigned DEF_IDX_W  = 4;
    localparam int unsigned TAG_W      = DEF_ADDR_W - DEF_OFF_W - DEF_IDX_W;
    localparam int unsigned SETS       = 2 ** DEF_IDX_W;

    typedef enum logic [1:0] {
        ST_E = 2'b00,
        ST_M = 2'b01,
        ST_S = 2'b10,
        ST_I = 2'b11
    } states_t;

    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_WRITE      = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_RWIM       = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        RES_HIT   = 2'b00,
        RES_HITM  = 2'b01,
        RES_NOHIT = 2'b10
    } snoop_result_t;

    // Outcome of one snoop lookup: bus result, next line state, error, write-back of state.
    typedef struct packed {
        snoop_result_t res;
        states_t       nxt;
        logic          err;
        logic          upd;
    } snoop_decision_t;

    // Snoop-induced MESI transition table; a miss never changes state.
    function automatic snoop_decision_t snoop_decide(logic hit, states_t cur, bus_op_t op);
        snoop_decision_t d;
        d.res = RES_NOHIT;
        d.nxt = cur;
        d.err = 1'b0;
        d.upd = 1'b0;
        if (hit) begin
            case (op)
                OP_READ: begin
                    d.res = (cur == ST_M) ? RES_HITM : RES_HIT;
                    d.nxt = ST_S;
                    d.upd = (cur != ST_S);
                end
                OP_RWIM: begin
                    d.res = (cur == ST_M) ? RES_HITM : RES_HIT;
                    d.nxt = ST_I;
                    d.upd = 1'b1;
                end
                OP_INVALIDATE: begin
                    // Only a shared copy may be invalidated; an owner seeing this is a protocol fault.
                    if (cur == ST_S) begin
                        d.res = RES_HIT;
                        d.nxt = ST_I;
                        d.upd = 1'b1;
                    end else begin
                        d.err = 1'b1;
                    end
                end
                default: begin
                    // Another cache writing a line we hold means ownership was lost.
                    d.err = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/mesi_snoop_tag_store.sv
// Purpose : Direct-mapped {tag, state} store for the snoop responder.
// Ports   : clk, rst (sync, active-high, all sets -> I / tag 0)
//           i_rd_idx -> o_rd_tag, o_rd_state  (combinational read)
//           i_wr_en, i_wr_idx, i_wr_tag, i_wr_state (single write port)
module mesi_snoop_tag_store
    import mesi_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W,
    parameter int unsigned TW    = TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [TW-1:0]    o_rd_tag,
    output states_t          o_rd_state,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TW-1:0]    i_wr_tag,
    input  states_t          i_wr_state
);

    localparam int unsigned NSETS = 2 ** IDX_W;

    logic [TW-1:0] r_tag   [NSETS];
    states_t       r_state [NSETS];

    // Storage update; reset invalidates every set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSETS; i++) begin
                r_tag[IDX_W'(i)]   <= '0;
                r_state[IDX_W'(i)] <= ST_I;
            end
        end else if (i_wr_en) begin
            r_tag[i_wr_idx]   <= i_wr_tag;
            r_state[i_wr_idx] <= i_wr_state;
        end
    end

    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_state = r_state[i_rd_idx];

endmodule

// File: rtl/mesi_snoop_responder.sv
// Purpose : Snoop responder. Accepts snooped bus ops, looks up the local
//           tag/state store, returns HIT/HITM/NOHIT, applies the MESI
//           transition and runs a writeback handshake on HITM.
// Ports   : clk, rst (sync, active-high)
//           snoop_valid/snoop_ready/snoop_op/snoop_addr : snoop request
//           result_valid/snoop_result                   : snoop response pulse
//           wb_valid/wb_ready/wb_addr                   : dirty-line writeback
//           fill_valid/fill_ready/fill_addr/fill_state  : local install port
//           protocol_err                                : illegal snoop pulse
module mesi_snoop_responder
    import mesi_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned OFF_W  = DEF_OFF_W,
    parameter int unsigned IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snoop_valid,
    output logic              snoop_ready,
    input  bus_op_t           snoop_op,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              result_valid,
    output snoop_result_t     snoop_result,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [ADDR_W-1:0] fill_addr,
    input  states_t           fill_state,
    output logic              protocol_err
);

    localparam int unsigned TW     = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned LINE_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESPOND,
        S_WRITEBACK
    } fsm_t;

    fsm_t            r_fsm;
    bus_op_t         r_op;
    logic [LINE_W-1:0] r_line;
    states_t         r_nxt;
    logic            r_upd;

    logic [IDX_W-1:0] w_idx;
    logic [TW-1:0]    w_tag;
    logic [TW-1:0]    w_rd_tag;
    states_t          w_rd_state;
    logic             w_hit;
    snoop_decision_t  w_dec;
    logic             w_fill_go;
    logic             w_commit;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TW-1:0]    w_wr_tag;
    states_t          w_wr_state;
    logic             w_unused_fill_off;

    assign w_idx = r_line[IDX_W-1:0];
    assign w_tag = r_line[LINE_W-1:IDX_W];

    assign w_hit = (w_rd_tag == w_tag) && (w_rd_state != ST_I);
    assign w_dec = snoop_decide(w_hit, w_rd_state, r_op);

    // Fills only land in IDLE with no snoop pending, so they never meet a RESPOND commit.
    assign fill_ready = !rst && (r_fsm == S_IDLE) && !snoop_valid;
    assign w_fill_go  = fill_valid && fill_ready;
    assign w_commit   = (r_fsm == S_RESPOND) && r_upd;

    assign w_wr_en    = w_fill_go || w_commit;
    assign w_wr_idx   = w_fill_go ? fill_addr[OFF_W+IDX_W-1:OFF_W] : w_idx;
    assign w_wr_tag   = w_fill_go ? fill_addr[ADDR_W-1:OFF_W+IDX_W] : w_tag;
    assign w_wr_state = w_fill_go ? fill_state : r_nxt;

    assign w_unused_fill_off = ^fill_addr[OFF_W-1:0];

    mesi_snoop_tag_store #(
        .IDX_W (IDX_W),
        .TW    (TW)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_idx),
        .o_rd_tag   (w_rd_tag),
        .o_rd_state (w_rd_state),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_tag   (w_wr_tag),
        .i_wr_state (w_wr_state)
    );

    // Snoop FSM with registered handshake/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= S_IDLE;
            r_op         <= OP_READ;
            r_line       <= '0;
            r_nxt        <= ST_I;
            r_upd        <= 1'b0;
            snoop_ready  <= 1'b1;
            result_valid <= 1'b0;
            snoop_result <= RES_NOHIT;
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            protocol_err <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            protocol_err <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (snoop_valid) begin
                        r_op        <= snoop_op;
                        r_line      <= snoop_addr[ADDR_W-1:OFF_W];
                        snoop_ready <= 1'b0;
                        r_fsm       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_nxt        <= w_dec.nxt;
                    r_upd        <= w_dec.upd;
                    result_valid <= 1'b1;
                    snoop_result <= w_dec.res;
                    protocol_err <= w_dec.err;
                    // Writeback request is raised alongside the HITM response.
                    if (w_dec.res == RES_HITM) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= {r_line, OFF_W'(0)};
                    end
                    r_fsm <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (wb_valid) begin
                        r_fsm <= S_WRITEBACK;
                    end else begin
                        snoop_ready <= 1'b1;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: begin
                    if (wb_ready) begin
                        wb_valid    <= 1'b0;
                        snoop_ready <= 1'b1;
                        r_fsm       <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
